// File: rtl/waterfall_pkg.sv
// -----------------------------------------------------------------------------
// waterfall_pkg
// Shared constants for the waterfall stage and its front-panel key controller.
//   - DEBOUNCE_CYCLES_DEFAULT / SYNC_STAGES_DEFAULT : parameter defaults
//   - FREQ_DIV*  : freq_set codes understood by the waterfall stage
//   - KEY_START / KEY_FREQ : bit positions inside key_level
//   - freq_next(): successor of a freq_set code (wraps DIV10 -> DIV1)
// -----------------------------------------------------------------------------
package waterfall_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;

  typedef logic [1:0] freq_code_t;

  localparam freq_code_t FREQ_DIV1  = 2'b00;
  localparam freq_code_t FREQ_DIV2  = 2'b01;
  localparam freq_code_t FREQ_DIV5  = 2'b10;
  localparam freq_code_t FREQ_DIV10 = 2'b11;

  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_FREQ  = 1;

  // Each freq-key press steps to the next divider setting, wrapping around.
  function automatic freq_code_t freq_next(input freq_code_t code);
    freq_code_t nxt;
    case (code)
      FREQ_DIV1: nxt = FREQ_DIV2;
      FREQ_DIV2: nxt = FREQ_DIV5;
      FREQ_DIV5: nxt = FREQ_DIV10;
      default:   nxt = FREQ_DIV1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Conditions one raw, active-low, bouncy push-button into a clean pressed
// level plus a one-cycle press indication.
//   clk      : system clock, rising edge
//   rst      : synchronous, active-high reset
//   key_n_i  : raw key, active-low, asynchronous to clk
//   level_o  : debounced level, 1 = pressed (registered)
//   press_o  : high for the single cycle after level_o rises (decoded from
//              registers only, so it carries no path from key_n_i)
//
// Pipeline for a clean press whose raw low is first sampled at edge 1:
//   edge SYNC_STAGES              : last synchronizer stage shows the press
//   edges SYNC_STAGES+1 ..        : counter counts 1, 2, ... DEBOUNCE_CYCLES-1
//   edge SYNC_STAGES+DEBOUNCE_CYCLES : level_o rises, press_o high after it
// -----------------------------------------------------------------------------
module key_debounce
  import waterfall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   level_dly_q;
  logic                   sample;

  // Shift the raw key in at bit 0; the oldest stage is the only one used.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_n_i};

  // Convert to the internal pressed-is-1 polarity after synchronization.
  assign sample = ~sync_q[SYNC_STAGES-1];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sample == level_q) begin
      // Any agreement, even for one cycle, restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
      level_d = sample;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizers reset to the released (high) value; a key held through
      // reset is then seen as a fresh press once reset is removed.
      sync_q      <= '1;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign level_o = level_q;
  // Rising edge of the debounced level only; releases are ignored.
  assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/waterfall_key_ctrl.sv
// -----------------------------------------------------------------------------
// waterfall_key_ctrl
// Front-panel controller for the waterfall stage: two debounced push-buttons
// generate a start pulse and step the frequency-select code.
//   clk         : system clock, rising edge
//   rst         : synchronous, active-high reset
//   key_start_n : raw start button, active-low, bouncy, asynchronous
//   key_freq_n  : raw frequency-select button, active-low, bouncy, asynchronous
//   start       : one-cycle pulse per start press (registered)
//   freq_set    : frequency code, advances by one per freq press (registered)
//   key_level   : debounced pressed state, bit0 = start, bit1 = freq
//
// A clean press reaches start/freq_set on edge SYNC_STAGES+DEBOUNCE_CYCLES+1
// after the raw input is first sampled low.
// -----------------------------------------------------------------------------
module waterfall_key_ctrl
  import waterfall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_freq_n,
  output logic       start,
  output logic [1:0] freq_set,
  output logic [1:0] key_level
);

  logic       press_start, press_freq;
  logic       level_start, level_freq;

  logic       start_q, start_d;
  freq_code_t freq_q, freq_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_key_start (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_start_n),
    .level_o (level_start),
    .press_o (press_start)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_key_freq (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_freq_n),
    .level_o (level_freq),
    .press_o (press_freq)
  );

  // The two keys are independent: simultaneous presses both act on the
  // same edge.
  always_comb begin
    start_d = press_start;
    freq_d  = press_freq ? freq_next(freq_q) : freq_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      freq_q  <= FREQ_DIV1;
    end else begin
      start_q <= start_d;
      freq_q  <= freq_d;
    end
  end

  assign start               = start_q;
  assign freq_set            = freq_q;
  assign key_level[KEY_START] = level_start;
  assign key_level[KEY_FREQ]  = level_freq;

endmodule

// File: tb/tb_waterfall_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_waterfall_key_ctrl
// Directed bench for waterfall_key_ctrl with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge, so the next rising edge is
// "edge 1" of that stimulus; outputs are read 1 time unit after each edge.
// With these parameters a clean press gives key_level at edge 6 and the
// start pulse / freq_set step at edge 7; a release drops key_level at edge 6.
// -----------------------------------------------------------------------------
module tb_waterfall_key_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_freq_n  = 1'b1;
  logic       start;
  logic [1:0] freq_set;
  logic [1:0] key_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  waterfall_key_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_start_n (key_start_n),
    .key_freq_n  (key_freq_n),
    .start       (start),
    .freq_set    (freq_set),
    .key_level   (key_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rst high for 2 cycles, then released with both keys idle.
  task automatic test_reset();
    rst = 1'b1;
    key_start_n = 1'b1;
    key_freq_n  = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      if (e == 3) rst = 1'b0;
      step();
      checks++;
      if ({start, freq_set, key_level} !== 5'b0_00_00) begin
        errors++;
        $display("FAIL reset edge %0d: start=%b freq_set=%b key_level=%b, expected 0 00 00",
                 e, start, freq_set, key_level);
      end
    end
  endtask

  // Clean start press held 20 cycles, then a clean release.
  task automatic test_start_press();
    logic       exp_start;
    logic [1:0] exp_level;
    key_start_n = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp_start = (e == 7);
      exp_level = (e >= 6) ? 2'b01 : 2'b00;
      checks++;
      if (start !== exp_start || freq_set !== 2'b00 || key_level !== exp_level) begin
        errors++;
        $display("FAIL start_press edge %0d: start=%b freq_set=%b key_level=%b, expected %b 00 %b",
                 e, start, freq_set, key_level, exp_start, exp_level);
      end
    end
    key_start_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_level = (e >= 6) ? 2'b00 : 2'b01;
      checks++;
      if (start !== 1'b0 || freq_set !== 2'b00 || key_level !== exp_level) begin
        errors++;
        $display("FAIL start_release edge %0d: start=%b freq_set=%b key_level=%b, expected 0 00 %b",
                 e, start, freq_set, key_level, exp_level);
      end
    end
  endtask

  // 3 cycles low / 1 cycle high, five times: always one short of the window.
  task automatic test_bounce();
    for (int e = 1; e <= 30; e++) begin
      key_start_n = (e <= 20) ? ((e % 4) == 0) : 1'b1;
      step();
      checks++;
      if (start !== 1'b0 || freq_set !== 2'b00 || key_level !== 2'b00) begin
        errors++;
        $display("FAIL bounce edge %0d: start=%b freq_set=%b key_level=%b, expected 0 00 00",
                 e, start, freq_set, key_level);
      end
    end
    key_start_n = 1'b1;
  endtask

  // Five clean freq presses: 01, 10, 11, 00, 01.
  task automatic test_freq_cycle();
    logic [1:0] exp_tab [5];
    logic [1:0] prev;
    logic [1:0] exp_freq;
    logic [1:0] exp_level;
    exp_tab = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    prev = 2'b00;
    for (int p = 0; p < 5; p++) begin
      key_freq_n = 1'b0;
      for (int e = 1; e <= 10; e++) begin
        step();
        exp_freq  = (e >= 7) ? exp_tab[p] : prev;
        exp_level = (e >= 6) ? 2'b10 : 2'b00;
        checks++;
        if (start !== 1'b0 || freq_set !== exp_freq || key_level !== exp_level) begin
          errors++;
          $display("FAIL freq_press%0d edge %0d: start=%b freq_set=%b key_level=%b, expected 0 %b %b",
                   p, e, start, freq_set, key_level, exp_freq, exp_level);
        end
      end
      key_freq_n = 1'b1;
      for (int e = 1; e <= 10; e++) begin
        step();
        exp_level = (e >= 6) ? 2'b00 : 2'b10;
        checks++;
        if (start !== 1'b0 || freq_set !== exp_tab[p] || key_level !== exp_level) begin
          errors++;
          $display("FAIL freq_release%0d edge %0d: start=%b freq_set=%b key_level=%b, expected 0 %b %b",
                   p, e, start, freq_set, key_level, exp_tab[p], exp_level);
        end
      end
      prev = exp_tab[p];
    end
  endtask

  // Both keys pressed on the same edge; freq_set is 01 on entry.
  task automatic test_simultaneous();
    logic       exp_start;
    logic [1:0] exp_freq;
    logic [1:0] exp_level;
    key_start_n = 1'b0;
    key_freq_n  = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_start = (e == 7);
      exp_freq  = (e >= 7) ? 2'b10 : 2'b01;
      exp_level = (e >= 6) ? 2'b11 : 2'b00;
      checks++;
      if (start !== exp_start || freq_set !== exp_freq || key_level !== exp_level) begin
        errors++;
        $display("FAIL simultaneous edge %0d: start=%b freq_set=%b key_level=%b, expected %b %b %b",
                 e, start, freq_set, key_level, exp_start, exp_freq, exp_level);
      end
    end
    key_start_n = 1'b1;
    key_freq_n  = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_level = (e >= 6) ? 2'b00 : 2'b11;
      checks++;
      if (start !== 1'b0 || freq_set !== 2'b10 || key_level !== exp_level) begin
        errors++;
        $display("FAIL simultaneous_release edge %0d: start=%b freq_set=%b key_level=%b, expected 0 10 %b",
                 e, start, freq_set, key_level, exp_level);
      end
    end
  endtask

  // Reset one cycle while a freq press has counted to 2; the key is let go
  // with the reset, so nothing may follow until a fresh press.
  task automatic test_reset_mid_debounce();
    logic [1:0] exp_freq;
    logic [1:0] exp_level;
    key_freq_n = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    rst        = 1'b1;
    key_freq_n = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (start !== 1'b0 || freq_set !== 2'b00 || key_level !== 2'b00) begin
      errors++;
      $display("FAIL mid_debounce_reset: start=%b freq_set=%b key_level=%b, expected 0 00 00",
               start, freq_set, key_level);
    end
    for (int e = 1; e <= 12; e++) begin
      step();
      checks++;
      if (start !== 1'b0 || freq_set !== 2'b00 || key_level !== 2'b00) begin
        errors++;
        $display("FAIL after_reset_idle edge %0d: start=%b freq_set=%b key_level=%b, expected 0 00 00",
                 e, start, freq_set, key_level);
      end
    end
    key_freq_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_freq  = (e >= 7) ? 2'b01 : 2'b00;
      exp_level = (e >= 6) ? 2'b10 : 2'b00;
      checks++;
      if (start !== 1'b0 || freq_set !== exp_freq || key_level !== exp_level) begin
        errors++;
        $display("FAIL repress_after_reset edge %0d: start=%b freq_set=%b key_level=%b, expected 0 %b %b",
                 e, start, freq_set, key_level, exp_freq, exp_level);
      end
    end
    key_freq_n = 1'b1;
    for (int e = 1; e <= 10; e++) step();
  endtask

  // Start key held low across reset: exactly one pulse after reset release.
  task automatic test_held_through_reset();
    logic       exp_start;
    logic [1:0] exp_level;
    int         pulses;
    key_start_n = 1'b0;
    rst = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step();
      checks++;
      if (start !== 1'b0 || freq_set !== 2'b00 || key_level !== 2'b00) begin
        errors++;
        $display("FAIL held_in_reset edge %0d: start=%b freq_set=%b key_level=%b, expected 0 00 00",
                 e, start, freq_set, key_level);
      end
    end
    rst = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (start === 1'b1) pulses++;
      exp_start = (e == 7);
      exp_level = (e >= 6) ? 2'b01 : 2'b00;
      checks++;
      if (start !== exp_start || freq_set !== 2'b00 || key_level !== exp_level) begin
        errors++;
        $display("FAIL held_through_reset edge %0d: start=%b freq_set=%b key_level=%b, expected %b 00 %b",
                 e, start, freq_set, key_level, exp_start, exp_level);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_through_reset pulse count: got %0d, expected 1", pulses);
    end
    key_start_n = 1'b1;
    for (int e = 1; e <= 10; e++) step();
  endtask

  initial begin
    test_reset();
    test_start_press();
    test_bounce();
    test_freq_cycle();
    test_simultaneous();
    test_reset_mid_debounce();
    test_held_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
